// File: rtl/cache_bus_pkg.sv
// ---------------------------------------------------------------------------
// cache_bus_pkg
// Shared definitions for the cache-side (C1) and memory-side (C2/D2/A2)
// buses: command/response codes, address field widths, line geometry and
// the memory responder's state/operation types.
// ---------------------------------------------------------------------------
package cache_bus_pkg;

    // Address geometry: A2 = {tag[9:0], set[4:0]}, byte offset lives on bus 1.
    localparam int unsigned TAG_W      = 10;
    localparam int unsigned SET_W      = 5;
    localparam int unsigned OFFSET_W   = 4;
    localparam int unsigned ADDR_W     = 15;

    // Line geometry: 16 bytes carried as 8 beats of 16 bits.
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned BEATS      = 8;
    localparam int unsigned BEAT_W     = 3;
    localparam int unsigned DATA_W     = 16;

    // Bus 2 (cache <-> memory) command/response codes.
    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_RESPONSE   = 2'd1;
    localparam logic [1:0] C2_READ_LINE  = 2'd2;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    // Bus 1 (CPU <-> cache) command/response codes.
    localparam logic [1:0] C1_NOP        = 2'd0;
    localparam logic [1:0] C1_READ       = 2'd1;
    localparam logic [1:0] C1_WRITE      = 2'd2;
    localparam logic [1:0] C1_RESPONSE   = 2'd3;

    typedef logic [ADDR_W-1:0] line_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_RECV,
        ST_WAIT,
        ST_RD_SEND,
        ST_WR_ACK
    } resp_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } resp_op_t;

    // True for the two codes that start a line transaction on bus 2.
    function automatic logic is_line_cmd(input logic [1:0] code);
        return (code == C2_READ_LINE) || (code == C2_WRITE_LINE);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// ---------------------------------------------------------------------------
// mem_line_array
// Backing store for the memory responder: MEM_LINES lines of BEATS 16-bit
// words, one synchronous read/write port. Contents are not reset.
//
// Ports:
//   i_clk    clock, rising edge
//   i_line   line index
//   i_beat   beat index within the line
//   i_we     write enable (i_wdata stored at {i_line, i_beat})
//   i_wdata  write data
//   o_rdata  registered read data of {i_line, i_beat} (old data on write)
// ---------------------------------------------------------------------------
module mem_line_array #(
    parameter int unsigned MEM_LINES = 32768,
    parameter int unsigned BEATS     = 8,
    parameter int unsigned LINE_W    = 15
) (
    input  logic              i_clk,
    input  logic [LINE_W-1:0] i_line,
    input  logic [2:0]        i_beat,
    input  logic              i_we,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata
);
    import cache_bus_pkg::*;

    localparam int unsigned DEPTH = MEM_LINES * BEATS;

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [LINE_W+BEAT_W-1:0] w_addr;

    assign w_addr = {i_line, i_beat};

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[w_addr] <= i_wdata;
        end
        o_rdata <= r_mem[w_addr];
    end

endmodule

// File: rtl/mem_line_responder.sv
// ---------------------------------------------------------------------------
// mem_line_responder
// Memory-side responder on bus 2. Accepts READ_LINE / WRITE_LINE from the
// cache controller, waits LATENCY idle cycles, then answers with
// C2=RESPONSE (plus 8 data beats for reads). C2 and D2 are only driven
// through registered enables and are high-Z otherwise.
//
// Ports:
//   clk    system clock, rising edge
//   RESET  asynchronous active-high reset; aborts any transfer in flight
//   A2     line address, sampled only when a command is accepted
//   C2     command/response bus (NOP/RESPONSE/READ_LINE/WRITE_LINE)
//   D2     16-bit data bus, beat i = {byte 2i, byte 2i+1}
//   busy   high from command acceptance until the bus is released
// ---------------------------------------------------------------------------
module mem_line_responder #(
    parameter int unsigned MEM_LINES  = 32768,
    parameter int unsigned LATENCY    = 16,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned BEATS      = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [14:0]      A2,
    inout  wire logic [1:0]  C2,
    inout  wire logic [15:0] D2,
    output logic             busy
);
    import cache_bus_pkg::*;

    localparam int unsigned LINE_W    = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int unsigned WAIT_W    = $clog2(LATENCY + 1);
    localparam int unsigned LAST_BEAT = LINE_BYTES / 2 - 1;

    resp_state_t       r_state;
    resp_state_t       w_state_nx;
    resp_op_t          r_op;
    logic [LINE_W-1:0] r_line;
    logic [BEAT_W-1:0] r_beat;
    logic [WAIT_W-1:0] r_wait;
    logic              r_c2_en;
    logic              r_d2_en;
    logic              r_busy;

    logic              w_cmd_rd;
    logic              w_cmd_wr;
    logic              w_last_beat;
    logic              w_wait_done;
    logic [LINE_W-1:0] w_a2_line;
    logic              w_mem_we;
    logic [LINE_W-1:0] w_mem_line;
    logic [BEAT_W-1:0] w_mem_beat;
    logic [DATA_W-1:0] w_rdata;

    // Line index is A2 modulo MEM_LINES; the upper address bits alias.
    assign w_a2_line = A2[LINE_W-1:0];

    generate
        if (LINE_W < ADDR_W) begin : g_alias_bits
            logic w_unused_a2_hi;
            assign w_unused_a2_hi = ^A2[ADDR_W-1:LINE_W];
        end
    endgenerate

    // Anything other than the two line commands (including Z/X) is a NOP.
    assign w_cmd_rd    = (C2 == C2_READ_LINE);
    assign w_cmd_wr    = (C2 == C2_WRITE_LINE);
    assign w_last_beat = (r_beat == BEAT_W'(LAST_BEAT));
    assign w_wait_done = (r_wait == WAIT_W'(1));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_rd) begin
                    w_state_nx = ST_WAIT;
                end else if (w_cmd_wr) begin
                    w_state_nx = ST_WR_RECV;
                end
            end
            ST_WR_RECV: begin
                if (w_last_beat) begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_wait_done) begin
                    w_state_nx = (r_op == OP_RD) ? ST_RD_SEND : ST_WR_ACK;
                end
            end
            ST_RD_SEND: begin
                if (w_last_beat) begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_WR_ACK: w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------ storage control
    // Beat 0 of a write is stored on the accepting edge, so in IDLE the
    // array is addressed straight from A2. While sending, the array is
    // addressed one beat ahead so its registered output lines up with the
    // beat being driven; the last WAIT cycle prefetches beat 0.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_line = r_line;
        w_mem_beat = r_beat;
        case (r_state)
            ST_IDLE: begin
                w_mem_we   = w_cmd_wr;
                w_mem_line = w_a2_line;
                w_mem_beat = '0;
            end
            ST_WR_RECV: w_mem_we   = 1'b1;
            ST_RD_SEND: w_mem_beat = r_beat + BEAT_W'(1);
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_line  <= '0;
            r_op    <= OP_RD;
            r_beat  <= '0;
            r_wait  <= '0;
            r_c2_en <= 1'b0;
            r_d2_en <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Enables follow the state being entered, so the bus is driven
            // from the first cycle of RD_SEND/WR_ACK.
            r_c2_en <= (w_state_nx == ST_RD_SEND) || (w_state_nx == ST_WR_ACK);
            r_d2_en <= (w_state_nx == ST_RD_SEND);
            r_busy  <= (w_state_nx != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_rd) begin
                        r_line <= w_a2_line;
                        r_op   <= OP_RD;
                        r_beat <= '0;
                        r_wait <= WAIT_W'(LATENCY);
                    end else if (w_cmd_wr) begin
                        r_line <= w_a2_line;
                        r_op   <= OP_WR;
                        r_beat <= BEAT_W'(1);
                    end
                end
                ST_WR_RECV: begin
                    r_beat <= r_beat + BEAT_W'(1);
                    if (w_last_beat) begin
                        r_wait <= WAIT_W'(LATENCY);
                    end
                end
                ST_WAIT:    r_wait <= r_wait - WAIT_W'(1);
                ST_RD_SEND: r_beat <= r_beat + BEAT_W'(1);
                default: ;
            endcase
        end
    end

    // Commands seen while a response is pending are dropped.
    always_ff @(posedge clk) begin
        if (!RESET && (r_state == ST_WAIT) && is_line_cmd(C2)) begin
            $warning("mem_line_responder: bus 2 command ignored while busy");
        end
    end

    mem_line_array #(
        .MEM_LINES (MEM_LINES),
        .BEATS     (BEATS),
        .LINE_W    (LINE_W)
    ) u_array (
        .i_clk   (clk),
        .i_line  (w_mem_line),
        .i_beat  (w_mem_beat),
        .i_we    (w_mem_we),
        .i_wdata (D2),
        .o_rdata (w_rdata)
    );

    assign C2   = r_c2_en ? C2_RESPONSE : 'z;
    assign D2   = r_d2_en ? w_rdata : 'z;
    assign busy = r_busy;

endmodule

// File: tb/tb_mem_line_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_line_responder
// Self-checking bench: plays the cache side of bus 2 and compares every
// response against a line-array model indexed by A2 modulo MEM_LINES.
// Released bus lines are pulled low, so high-Z reads back as zero.
// ---------------------------------------------------------------------------
module tb_mem_line_responder;

    localparam int unsigned MEM_LINES = 32;
    localparam int unsigned LATENCY   = 16;

    localparam logic [1:0] NOP   = 2'd0;
    localparam logic [1:0] RESP  = 2'd1;
    localparam logic [1:0] RDL   = 2'd2;
    localparam logic [1:0] WRL   = 2'd3;

    logic        clk   = 1'b0;
    logic        RESET = 1'b1;
    logic [14:0] A2    = '0;
    wire  [1:0]  C2;
    wire  [15:0] D2;
    logic        busy;

    logic        tb_c2_en = 1'b0;
    logic [1:0]  tb_c2    = '0;
    logic        tb_d2_en = 1'b0;
    logic [15:0] tb_d2    = '0;

    assign C2 = tb_c2_en ? tb_c2 : 2'bzz;
    assign D2 = tb_d2_en ? tb_d2 : 16'hzzzz;
    pulldown (C2);
    pulldown (D2);

    always #5 clk = ~clk;

    mem_line_responder #(
        .MEM_LINES  (MEM_LINES),
        .LATENCY    (LATENCY),
        .LINE_BYTES (16),
        .BEATS      (8)
    ) dut (
        .clk   (clk),
        .RESET (RESET),
        .A2    (A2),
        .C2    (C2),
        .D2    (D2),
        .busy  (busy)
    );

    logic [15:0] model [MEM_LINES][8];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0][15:0] rand_line();
        logic [7:0][15:0] r;
        for (int i = 0; i < 8; i++) r[i] = 16'($urandom);
        return r;
    endfunction

    // Waits for the read response (already = cycles elapsed since accept),
    // then checks latency, all 8 beats and the release cycle.
    task automatic collect_read(input logic [14:0] a, input int already);
        int n;
        bit got;
        int idx;
        idx = int'(a) % MEM_LINES;
        n = already;
        got = 0;
        while (n < int'(LATENCY) + 4 && !got) begin
            tick;
            n++;
            if (C2 === RESP) got = 1;
        end
        n_tests++;
        if (!got || n != int'(LATENCY)) begin
            n_fail++;
            $display("FAIL rd_latency a=%h: got %0d cycles (seen=%0d), expected %0d", a, n, got, LATENCY);
        end
        if (!got) return;
        for (int b = 0; b < 8; b++) begin
            if (b > 0) tick;
            n_tests++;
            if (C2 !== RESP || D2 !== model[idx][b]) begin
                n_fail++;
                $display("FAIL rd_beat a=%h b=%0d: got C2=%h D2=%h, expected C2=%h D2=%h",
                         a, b, C2, D2, RESP, model[idx][b]);
            end
        end
        tick;
        n_tests++;
        if (C2 !== NOP || D2 !== 16'h0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_release a=%h: got C2=%h D2=%h busy=%b, expected 0/0000/0", a, C2, D2, busy);
        end
    endtask

    task automatic do_read(input logic [14:0] a);
        tb_c2 = RDL; tb_c2_en = 1'b1; A2 = a;
        tick;
        tb_c2_en = 1'b0;
        A2 = 15'($urandom);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_busy a=%h: got %b, expected 1", a, busy);
        end
        collect_read(a, 0);
    endtask

    task automatic do_write(input logic [14:0] a, input logic [7:0][15:0] d);
        int n;
        bit got;
        tb_c2 = WRL; tb_c2_en = 1'b1; A2 = a;
        tb_d2 = d[0]; tb_d2_en = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick;
            if (i == 1) begin
                A2 = 15'($urandom);
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wr_busy a=%h: got %b, expected 1", a, busy);
                end
            end
            tb_d2 = d[i];
        end
        tick;
        tb_c2_en = 1'b0; tb_d2_en = 1'b0;
        for (int j = 0; j < 8; j++) model[int'(a) % MEM_LINES][j] = d[j];
        n = 0;
        got = 0;
        while (n < int'(LATENCY) + 4 && !got) begin
            tick;
            n++;
            if (C2 === RESP) got = 1;
        end
        n_tests++;
        if (!got || n != int'(LATENCY)) begin
            n_fail++;
            $display("FAIL wr_ack_latency a=%h: got %0d cycles after beat 7 edge (seen=%0d), expected %0d",
                     a, n, got, LATENCY);
        end
        if (!got) return;
        n_tests++;
        if (D2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL wr_ack_d2 a=%h: got D2=%h, expected undriven (0000)", a, D2);
        end
        tick;
        n_tests++;
        if (C2 !== NOP || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack_release a=%h: got C2=%h busy=%b, expected 0/0", a, C2, busy);
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) tick;
        n_tests++;
        if (C2 !== NOP || D2 !== 16'h0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus: got C2=%h D2=%h busy=%b, expected 0/0000/0", C2, D2, busy);
        end
        RESET = 1'b0;
        tick;
        do_read(15'h0000);
    endtask

    task automatic test_write_read;
        logic [7:0][15:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i][15:8] = 8'(2 * i * 17);
            p[i][7:0]  = 8'((2 * i + 1) * 17);
        end
        n_tests++;
        if (p[7] !== 16'hEEFF) begin
            n_fail++;
            $display("FAIL pattern_build: got %h, expected eeff", p[7]);
        end
        do_write(15'h1234, p);
        do_read(15'h1234);
    endtask

    task automatic test_reset_mid_read;
        int n;
        bit got;
        int idx;
        idx = 15'h1234 % MEM_LINES;
        tb_c2 = RDL; tb_c2_en = 1'b1; A2 = 15'h1234;
        tick;
        tb_c2_en = 1'b0;
        n = 0;
        got = 0;
        while (n < int'(LATENCY) + 4 && !got) begin
            tick;
            n++;
            if (C2 === RESP) got = 1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL rmr_start: got no response in %0d cycles, expected one after %0d", n, LATENCY);
        end
        for (int b = 0; b < 4 && got; b++) begin
            if (b > 0) tick;
            n_tests++;
            if (D2 !== model[idx][b]) begin
                n_fail++;
                $display("FAIL rmr_beat b=%0d: got %h, expected %h", b, D2, model[idx][b]);
            end
        end
        #2 RESET = 1'b1;
        #1;
        n_tests++;
        if (C2 !== NOP || D2 !== 16'h0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmr_async_release: got C2=%h D2=%h busy=%b, expected 0/0000/0", C2, D2, busy);
        end
        @(posedge clk);
        @(posedge clk);
        #1 RESET = 1'b0;
        tick;
        do_read(15'h1234);
    endtask

    task automatic test_aliasing;
        logic [7:0][15:0] p;
        p = rand_line();
        p[0] = p[0] | 16'h0101;
        do_write(15'd5, p);
        do_read(15'd37);
        do_read(15'd6);
    endtask

    task automatic test_busy_collision;
        logic [7:0][15:0] junk;
        junk = rand_line();
        junk[0] = junk[0] | 16'h8000;
        tb_c2 = RDL; tb_c2_en = 1'b1; A2 = 15'd1;
        tick;
        tb_c2_en = 1'b0;
        tick;
        tick;
        tb_c2 = WRL; tb_c2_en = 1'b1; A2 = 15'd2;
        tb_d2 = junk[0]; tb_d2_en = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick;
            tb_d2 = junk[i];
        end
        tick;
        tb_c2_en = 1'b0; tb_d2_en = 1'b0;
        collect_read(15'd1, 10);
        do_read(15'd2);
    endtask

    task automatic test_back_to_back;
        logic [14:0] a;
        a = 15'($urandom_range(0, 32767));
        do_write(a, rand_line());
        do_read(a);
        do_read(a ^ 15'h0020);
    endtask

    task automatic test_random;
        logic [14:0] a;
        for (int k = 0; k < 12; k++) begin
            a = 15'($urandom_range(0, 32767));
            if ($urandom_range(0, 1) == 0) do_write(a, rand_line());
            else do_read(a);
        end
    endtask

    initial begin
        for (int l = 0; l < int'(MEM_LINES); l++)
            for (int b = 0; b < 8; b++) model[l][b] = '0;
        test_reset;
        test_write_read;
        test_reset_mid_read;
        test_aliasing;
        test_busy_collision;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run by 500000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
